// File: rtl/tri_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tri_fetch_seq
//  Purpose  : Walks triangle indices 0..num_tris-1, issues one tri_reader
//             read per index, buffers returned blocks (tagged with their
//             index) in an in-order first-word-fall-through FIFO and streams
//             them to the intersection stage over valid/ready. A credit rule
//             bounds outstanding reads so the FIFO can never overflow.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             start/num_tris/baseaddr - pass launch (sampled when idle)
//             busy/done/err           - pass status, sticky protocol error
//             rd_*                    - request/return side of tri_reader
//             tri_*                   - output stream (head of return FIFO)
//  Revision : 1.0 - initial release
// ============================================================================
module tri_fetch_seq #(
   parameter int NDWORDS    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [31:0]             num_tris,
   input  logic [31:0]             baseaddr,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [31:0]             rd_baseaddr,
   output logic [31:0]             rd_index,
   output logic                    rd_read,
   input  logic                    rd_ready,
   input  logic [32*NDWORDS-1:0]   rd_data,
   input  logic                    rd_valid,
   output logic [32*NDWORDS-1:0]   tri_data,
   output logic [31:0]             tri_index,
   output logic                    tri_last,
   output logic                    tri_valid,
   input  logic                    tri_ready
);

   localparam int BLOCKSZ = 32 * NDWORDS;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t              state_q;
   logic [31:0]         num_q;
   logic [31:0]         base_q;
   logic [31:0]         issued_q;
   logic [31:0]         returned_q;
   logic [CW-1:0]       count_q;
   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic                err_q;

   logic [BLOCKSZ-1:0]  data_mem [FIFO_DEPTH];
   logic [31:0]         idx_mem  [FIFO_DEPTH];

   logic [31:0]         outstanding;
   logic                accept;
   logic                pop;
   logic                push;
   logic                full;
   logic                bad_valid;
   logic                start_ok;
   logic [CW-1:0]       count_d;

   assign outstanding = issued_q - returned_q;

   // Credit: a read may only be in flight if a FIFO slot is reserved for it.
   assign rd_read   = (state_q == S_ISSUE) &&
                      (({1'b0, outstanding} + 33'(count_q)) < 33'(FIFO_DEPTH));
   assign accept    = rd_read & rd_ready;
   assign tri_valid = (count_q != '0);
   assign pop       = tri_valid & tri_ready;
   assign full      = (count_q == CW'(FIFO_DEPTH));
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign bad_valid = rd_valid & ((outstanding == 32'd0) | (full & ~pop));
   assign push      = rd_valid & ~bad_valid;
   assign start_ok  = start & (state_q == S_IDLE);
   assign count_d   = count_q + CW'(push) - CW'(pop);

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_FINISH);
   assign err         = err_q;
   assign rd_baseaddr = base_q;
   assign rd_index    = issued_q;
   // Head is forced to zero when empty so stale entries never leak out.
   assign tri_data    = tri_valid ? data_mem[rd_ptr_q] : '0;
   assign tri_index   = tri_valid ? idx_mem[rd_ptr_q]  : '0;
   assign tri_last    = tri_valid && (tri_index == (num_q - 32'd1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         num_q      <= '0;
         base_q     <= '0;
         issued_q   <= '0;
         returned_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
      end else if (start_ok) begin
         num_q      <= num_tris;
         base_q     <= baseaddr;
         issued_q   <= '0;
         returned_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         state_q    <= (num_tris == 32'd0) ? S_FINISH : S_ISSUE;
      end else begin
         if (accept)    issued_q   <= issued_q + 32'd1;
         if (push) begin
            returned_q <= returned_q + 32'd1;
            wr_ptr_q   <= wr_ptr_q + AW'(1);
         end
         if (pop)       rd_ptr_q   <= rd_ptr_q + AW'(1);
         if (bad_valid) err_q      <= 1'b1;
         count_q <= count_d;

         case (state_q)
            S_ISSUE: begin
               if (accept && ((issued_q + 32'd1) == num_q))
                  state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop && tri_last)
                  state_q <= S_FINISH;
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // Storage needs no reset: visibility is governed by count/pointers only.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= rd_data;
         idx_mem[wr_ptr_q]  <= returned_q;
      end
   end

endmodule
`default_nettype wire

// File: doc/tri_fetch_seq.md
# tri_fetch_seq

Request sequencer and return buffer that sits directly upstream and downstream of `tri_reader`. It walks triangle indices 0..num_tris-1 and issues one `tri_reader` read per index. It buffers the returned triangle words in an in-order FIFO tagged with their index, and hands them to the intersection stage over a valid/ready stream. A credit rule bounds outstanding reads so the FIFO can never overflow.

## Interface
Parameters:
- `NDWORDS`, 1, 32-bit words per triangle block; data width is `BLOCKSZ = 32*NDWORDS`
- `FIFO_DEPTH`, 4, return FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a pass, ignored unless idle
- `num_tris`  in  32  triangle count, sampled on accepted `start`
- `baseaddr`  in  32  triangle table base, sampled on accepted `start`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of pass
- `err`  out  1  sticky protocol error; cleared by reset or accepted `start`
- `rd_baseaddr`  out  32  to `tri_reader.baseaddr`; latched `baseaddr`
- `rd_index`  out  32  to `tri_reader.index`
- `rd_read`  out  1  to `tri_reader.read`
- `rd_ready`  in  1  from `tri_reader.iready`
- `rd_data`  in  BLOCKSZ  from `tri_reader.data`
- `rd_valid`  in  1  from `tri_reader.ovalid`
- `tri_data`  out  BLOCKSZ  FIFO head data
- `tri_index`  out  32  index of FIFO head
- `tri_last`  out  1  head is index num_tris-1
- `tri_valid`  out  1  FIFO non-empty
- `tri_ready`  in  1  consumer accepts head

## Operation
- States:
  - IDLE: `start` -> ISSUE, or -> FINISH if `num_tris`==0.
  - ISSUE: go to DRAIN when the issued count reaches num_tris.
  - DRAIN: go to FINISH on the pop of the entry with `tri_last`.
  - FINISH: asserts `done` for one cycle, then returns to IDLE.
- Counters, all 32-bit unsigned:
  - `issued` increments on accept, where accept = `rd_read & rd_ready`.
  - `returned` increments on every `rd_valid`.
  - `outstanding` = issued - returned.
  - `count` = FIFO occupancy.
- Credit rule: `rd_read` = (state==ISSUE) & (outstanding + count < FIFO_DEPTH). It is combinational from registered state only, so it does not depend on `rd_ready`.
- `rd_index` = `issued`; it holds stable while `rd_read` is high and not accepted.
- Return path: each `rd_valid` pushes {`rd_data`, `returned`} into the FIFO. Returns are in issue order.
- FIFO is registered, first-word fall-through.
- Simultaneous push and pop leaves `count` unchanged. Pop happens on `tri_valid & tri_ready`.
- `tri_last` = (`tri_index` == num_tris-1) & `tri_valid`.
- Error conditions, each drops the word and sets `err`:
  - `rd_valid` while `outstanding`==0;
  - `rd_valid` while the FIFO is full and not popping in the same cycle.
- `start` while `busy` is ignored, and latched values are unchanged.
- A new `start` clears `issued`, `returned`, the FIFO and `err`.
- Asynchronous reset mid-pass discards all state. The block returns to IDLE with every counter at 0. A reader still in flight must be reset by the same `reset_n`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rd_read`=0, `rd_index`=0, `rd_baseaddr`=0, `tri_valid`=0, `tri_last`=0, `tri_index`=0, `tri_data`=0.
- Pass start: `start` sampled at edge T gives `busy`=1 after T. The first `rd_read` (index 0) appears in the cycle after T.
- Issue rate: at most one read per cycle, also gated by `rd_ready`.
- Return latency: `rd_valid` high at edge C gives `tri_valid` high after C, one cycle push-to-visible.
- End of pass: the last pop at edge L puts the block in FINISH after L, with `done`=1 for one cycle. `busy`=0 and IDLE follow after L+1.
- `num_tris`==0: `done` pulses in the cycle after `start`, with no reads issued.
- Credit bound: outstanding + count never exceeds FIFO_DEPTH.

## Test plan
- Basic pass: reset, then `num_tris`=3, `baseaddr`=0, reader returns 0x000a000b, 0x00010002, 0x00030004, `tri_ready`=1.
  - Expect `rd_index` 0,1,2.
  - Expect `tri_index` 0,1,2 with matching data, and `tri_last` only on index 2.
  - Expect one `done` pulse, with `err`=0.
- Backpressure: `num_tris`=8 with `tri_ready`=0 throughout.
  - Issue stops after 4 accepts (FIFO_DEPTH=4), and `rd_read` stays 0.
  - Releasing `tri_ready` resumes issue, and all 8 indices are delivered in order.
- Reader stall: `rd_ready` low for 5 cycles with `rd_read` high.
  - `rd_index` is held constant and no count increments during the stall.
- Zero count: `num_tris`=0 -> `done` one cycle after `start`, no `rd_read`, `tri_valid` never 1.
- Errors and ignored start:
  - A spurious `rd_valid` in IDLE -> `err`=1 and it stays high.
  - A `start` during a pass is ignored.
  - The next accepted `start` clears `err`.
- Mid-pass reset: deassert `reset_n` after 2 of 6 returns.
  - All outputs take reset values immediately.
  - A following `start` with `num_tris`=2 completes cleanly.
